wrr_pkt_arbiter: RTL

Weighted round-robin packet arbiter that shares one downstream beat channel between NUM_PORTS requesters. Ownership is held for a full multi-beat packet, closed by the owner's last flag. A port may keep ownership for up to its programmed weight of consecutive packets before priority rotates. It sits in front of the shared egress datapath and extends the single-cycle round-robin grant with packet locking, weighting and a downstream ready handshake.

---
 rtl/wrr_arb_pkg.sv | 11 +
 rtl/wrr_pkt_arbiter_rr_pick.sv | 35 +++
 rtl/wrr_pkt_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package wrr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  localparam int W2 = 2 * N;

  logic [W2-1:0] dreq;
  logic [W2-1:0] mask;
  logic [W2-1:0] masked;
  logic [W2-1:0] lowest;

  // The upper copy of req supplies the wrapped-around candidates below ptr.
  assign dreq     = {req_i, req_i};
  assign mask     = {W2{1'b1}} << ptr_i;
  assign masked   = dreq & mask;
  assign lowest   = masked & (~masked + W2'(1));
  assign gnt_oh_o = lowest[N-1:0] | lowest[W2-1:N];
  assign found_o  = |req_i;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh_o[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: grants are held for whole packets and
// an owner may keep the channel for up to its weight of consecutive packets.
module wrr_pkt_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  localparam int IW       = idx_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          last_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
  input  logic                          ready_i,
  output logic [NUM_PORTS-1:0]          gnt_o,
  output logic                          gnt_valid_o,
  output logic [IW-1:0]                 gnt_id_o,
  output logic                          pkt_done_o
);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_id_q, gnt_id_d;
  logic [WEIGHT_W-1:0]  cred_q, cred_d;
  logic [WEIGHT_W-1:0]  wgt_q, wgt_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;

  logic [NUM_PORTS-1:0] pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic [IW-1:0]        win;
  logic [WEIGHT_W:0]    cred_inc;
  logic                 xfer;
  logic                 pkt_end;

  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  function automatic logic [WEIGHT_W-1:0] sat_inc(input logic [WEIGHT_W-1:0] c);
    return (&c) ? c : c + WEIGHT_W'(1);
  endfunction

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_oh_o(pick_oh),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign xfer       = (state_q == ARB_BUSY) && req_i[owner_q] && ready_i;
  assign pkt_end    = xfer && last_i[owner_q];
  assign pkt_done_o = pkt_end && !reset;
  assign cred_inc   = {1'b0, cred_q} + (WEIGHT_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cred_d      = cred_q;
    wgt_d       = wgt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    win         = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          // A turn in progress survives only if the owner is back immediately.
          if (cred_q != '0 && req_i[owner_q]) begin
            win = owner_q;
          end else begin
            win    = pick_idx;
            cred_d = '0;
          end
          owner_d     = win;
          gnt_d       = NUM_PORTS'(1) << win;
          gnt_id_d    = win;
          gnt_valid_d = 1'b1;
          wgt_d       = eff_weight(weight_i[win*WEIGHT_W +: WEIGHT_W]);
          state_d     = ARB_BUSY;
        end else begin
          cred_d = '0;
        end
      end
      ARB_BUSY: begin
        if (pkt_end) begin
          state_d     = ARB_IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          if (cred_inc >= {1'b0, wgt_q}) begin
            cred_d = '0;
            ptr_d  = (owner_q == IW'(NUM_PORTS - 1)) ? '0 : owner_q + IW'(1);
          end else begin
            cred_d = sat_inc(cred_q);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      cred_q      <= '0;
      wgt_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cred_q      <= cred_d;
      wgt_q       <= wgt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule
